// File: rtl/texture_mapper_legup_div_sequential_if.sv
// Operand/result bundle for the sequential divider: requester drives the
// master side, the divider sits on the slave side.
interface texture_mapper_legup_div_sequential_if #(
    parameter int widthn = 32,
    parameter int widthd = 32
);
    logic              clken;
    logic              start;
    logic [widthn-1:0] numer;
    logic [widthd-1:0] denom;
    logic              busy;
    logic              done;
    logic [widthn-1:0] quotient;
    logic [widthd-1:0] remain;
    logic              div_by_zero;

    modport master (
        output clken, start, numer, denom,
        input  busy, done, quotient, remain, div_by_zero
    );

    modport slave (
        input  clken, start, numer, denom,
        output busy, done, quotient, remain, div_by_zero
    );
endinterface

// File: rtl/texture_mapper_legup_div_sequential.sv
// Multi-cycle restoring divider (one quotient bit per enabled clock), unsigned or signed.
// Optional zero-divisor short-cut: define TEXTURE_MAPPER_LEGUP_DIV_ZERO_DETECT_EN.
module texture_mapper_legup_div_sequential #(
    parameter int    widthn         = 32,
    parameter int    widthd         = 32,
    parameter string representation = "UNSIGNED"
) (
    input  logic clock,
    input  logic resetn,
    texture_mapper_legup_div_sequential_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam bit is_signed = (representation == "SIGNED");
    localparam int cnt_w     = $clog2(widthn + 1);

`ifdef TEXTURE_MAPPER_LEGUP_DIV_ZERO_DETECT_EN
    localparam bit zero_detect = 1'b1;
`else
    localparam bit zero_detect = 1'b0;
`endif

    logic [1:0]        state_reg, state_next;
    logic [cnt_w-1:0]  count_reg, count_next;
    logic [widthn-1:0] q_reg, q_next;
    logic [widthd-1:0] r_reg, r_next;
    logic [widthd-1:0] d_reg, d_next;
    logic              neg_q_reg, neg_q_next;
    logic              neg_r_reg, neg_r_next;
    logic              dbz_pend_reg, dbz_pend_next;
    logic [widthn-1:0] quotient_reg, quotient_next;
    logic [widthd-1:0] remain_reg, remain_next;
    logic              dbz_reg, dbz_next;

    logic              numer_neg, denom_neg, zero_start, fits;
    logic [widthn-1:0] numer_mag;
    logic [widthd-1:0] denom_mag;
    logic [widthd:0]   r_shift;

    // Signed operands are divided as magnitudes; signs are reapplied at writeback.
    assign numer_neg  = is_signed && bus.numer[widthn-1];
    assign denom_neg  = is_signed && bus.denom[widthd-1];
    assign numer_mag  = numer_neg ? -bus.numer : bus.numer;
    assign denom_mag  = denom_neg ? -bus.denom : bus.denom;
    assign zero_start = zero_detect && (bus.denom == '0);

    // q_reg shifts the dividend out of its MSB while quotient bits enter at the LSB.
    assign r_shift = {r_reg, q_reg[widthn-1]};
    assign fits    = (r_shift >= {1'b0, d_reg});

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        q_next        = q_reg;
        r_next        = r_reg;
        d_next        = d_reg;
        neg_q_next    = neg_q_reg;
        neg_r_next    = neg_r_reg;
        dbz_pend_next = dbz_pend_reg;
        quotient_next = quotient_reg;
        remain_next   = remain_reg;
        dbz_next      = dbz_reg;

        case (state_reg)
            IDLE, DONE: begin
                state_next = IDLE;
                if (bus.start) begin
                    state_next = CALC;
                    d_next     = denom_mag;
                    if (zero_start) begin
                        // Zero count makes the next enabled edge the writeback edge.
                        count_next    = '0;
                        q_next        = '1;
                        r_next        = bus.numer[widthd-1:0];
                        neg_q_next    = 1'b0;
                        neg_r_next    = 1'b0;
                        dbz_pend_next = 1'b1;
                    end else begin
                        count_next    = cnt_w'(widthn);
                        q_next        = numer_mag;
                        r_next        = '0;
                        neg_q_next    = numer_neg ^ denom_neg;
                        neg_r_next    = numer_neg;
                        dbz_pend_next = 1'b0;
                    end
                end
            end
            CALC: begin
                if (count_reg == '0) begin
                    state_next    = DONE;
                    quotient_next = neg_q_reg ? -q_reg : q_reg;
                    remain_next   = neg_r_reg ? -r_reg : r_reg;
                    dbz_next      = dbz_pend_reg;
                end else begin
                    count_next = count_reg - cnt_w'(1);
                    q_next     = {q_reg[widthn-2:0], fits};
                    r_next     = fits ? widthd'(r_shift - {1'b0, d_reg}) : widthd'(r_shift);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            q_reg        <= '0;
            r_reg        <= '0;
            d_reg        <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            dbz_pend_reg <= 1'b0;
            quotient_reg <= '0;
            remain_reg   <= '0;
            dbz_reg      <= 1'b0;
        end else if (bus.clken) begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            q_reg        <= q_next;
            r_reg        <= r_next;
            d_reg        <= d_next;
            neg_q_reg    <= neg_q_next;
            neg_r_reg    <= neg_r_next;
            dbz_pend_reg <= dbz_pend_next;
            quotient_reg <= quotient_next;
            remain_reg   <= remain_next;
            dbz_reg      <= dbz_next;
        end
    end

    assign bus.busy        = (state_reg == CALC);
    assign bus.done        = (state_reg == DONE);
    assign bus.quotient    = quotient_reg;
    assign bus.remain      = remain_reg;
    assign bus.div_by_zero = zero_detect ? dbz_reg : 1'b0;

endmodule
